smg_scan_sched: RTL

SMG_SCAN_SCHED -- requirements
Module: smg_scan_sched

---
 rtl/smg_scan_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/smg_scan_sched.sv
// Time-multiplexed 4-digit display scanner with two requesters arbitrated once per frame.
// Every output is registered and lags the slot/digit counter state by one cycle.
module smg_scan_sched #(
  parameter logic [31:0] TICK_DIV = 32'd12_500,
  parameter logic [31:0] BLANK    = 32'd250
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  dp_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  dp_b,
  input  logic        lz_en,
  output logic        ack_a,
  output logic        ack_b,
  output logic [3:0]  smg_en,
  output logic [3:0]  Q,
  output logic        h,
  output logic        frame_start
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  logic [31:0] cnt_q;
  logic [1:0]  dig_q;
  logic [15:0] disp_q;
  logic [3:0]  dp_q;
  ptr_e        ptr_q;
  logic        pend_a_q, pend_b_q, lz_q;
  logic        ack_a_q, ack_b_q, fs_q, h_q;
  logic [3:0]  smg_en_q, q_q;

  logic        slot_end_s, bnd_s, gnt_a_s, gnt_b_s, lz_act_s, hide_s, on_s;
  logic [3:0]  nib_s;

  assign slot_end_s = (cnt_q == TICK_DIV - 32'd1);
  assign bnd_s      = slot_end_s && (dig_q == 2'd3);
  assign gnt_a_s    = bnd_s && req_a && (!req_b || (ptr_q == PTR_A));
  assign gnt_b_s    = bnd_s && req_b && (!req_a || (ptr_q == PTR_B));
  // lz_en is taken live on the first cycle of a slot and held for the rest of it
  assign lz_act_s   = (cnt_q == 32'd0) ? lz_en : lz_q;
  assign nib_s      = disp_q[{dig_q, 2'b00} +: 4];

  // Digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    hide_s = 1'b0;
    case (dig_q)
      2'd3:    hide_s = (disp_q[15:12] == 4'h0);
      2'd2:    hide_s = (disp_q[15:8] == 8'h00);
      2'd1:    hide_s = (disp_q[15:4] == 12'h000);
      default: hide_s = 1'b0;
    endcase
  end

  assign on_s = (cnt_q >= BLANK) && !(lz_act_s && hide_s);

  // Scan counters, frame-boundary arbitration and registered outputs
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cnt_q    <= 32'd0;
      dig_q    <= 2'd0;
      disp_q   <= 16'h0000;
      dp_q     <= 4'h0;
      ptr_q    <= PTR_A;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lz_q     <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      fs_q     <= 1'b0;
      h_q      <= 1'b0;
      smg_en_q <= 4'h0;
      q_q      <= 4'h0;
    end else begin
      cnt_q <= slot_end_s ? 32'd0 : cnt_q + 32'd1;
      if (slot_end_s) dig_q <= dig_q + 2'd1;
      if (cnt_q == 32'd0) lz_q <= lz_en;

      smg_en_q <= on_s ? (4'b0001 << dig_q) : 4'b0000;
      q_q      <= on_s ? nib_s : 4'h0;
      h_q      <= on_s ? dp_q[dig_q] : 1'b0;
      fs_q     <= (cnt_q == 32'd0) && (dig_q == 2'd0);

      // Grant is latched at the boundary; its ack lands one cycle later with frame_start
      ack_a_q  <= pend_a_q;
      ack_b_q  <= pend_b_q;
      pend_a_q <= gnt_a_s;
      pend_b_q <= gnt_b_s;

      if (gnt_a_s) begin
        disp_q <= data_a;
        dp_q   <= dp_a;
      end else if (gnt_b_s) begin
        disp_q <= data_b;
        dp_q   <= dp_b;
      end
      if (bnd_s && req_a && req_b) ptr_q <= (ptr_q == PTR_A) ? PTR_B : PTR_A;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign smg_en      = smg_en_q;
  assign Q           = q_q;
  assign h           = h_q;
  assign frame_start = fs_q;

endmodule
